// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the radix-2 DIF FFT stage sequencer: state codes and
// the per-pair address/twiddle arithmetic used by the sequencer.
package fft_stage_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int unsigned fft_span(input int unsigned s, input int unsigned n);
    return n >> (s + 1);
  endfunction

  // Upper-leg address: insert a zero bit at the span position of j.
  function automatic int unsigned fft_rd_addr(input int unsigned j, input int unsigned s,
                                              input int unsigned n);
    int unsigned mask;
    mask = fft_span(s, n) - 1;
    return (j & mask) | ((j & ~mask) << 1);
  endfunction

  function automatic int unsigned fft_tf_addr(input int unsigned j, input int unsigned s,
                                              input int unsigned n);
    int unsigned mask;
    mask = fft_span(s, n) - 1;
    return ((j & mask) << s) & ((n >> 1) - 1);
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Bus between the FFT stage sequencer (master) and the BRAM/butterfly datapath (slave).
interface fft_stage_sequencer_if #(
  parameter int N = 64
);
  localparam int ADDR_WIDTH    = $clog2(N);
  localparam int TF_ADDR_WIDTH = $clog2(N / 2);
  localparam int STAGE_WIDTH   = $clog2(ADDR_WIDTH + 1);

  logic                     start;
  logic                     rd_en;
  logic                     rd_bank;
  logic [ADDR_WIDTH-1:0]    rd_addr_a;
  logic [ADDR_WIDTH-1:0]    rd_addr_b;
  logic [TF_ADDR_WIDTH-1:0] tf_addr;
  logic                     wr_en;
  logic                     wr_bank;
  logic [ADDR_WIDTH-1:0]    wr_addr_a;
  logic [ADDR_WIDTH-1:0]    wr_addr_b;
  logic [STAGE_WIDTH-1:0]   stage;
  logic                     busy;
  logic                     done;
  logic                     result_bank;

  modport master (
    input  start,
    output rd_en, rd_bank, rd_addr_a, rd_addr_b, tf_addr,
    output wr_en, wr_bank, wr_addr_a, wr_addr_b,
    output stage, busy, done, result_bank
  );

  modport slave (
    output start,
    input  rd_en, rd_bank, rd_addr_a, rd_addr_b, tf_addr,
    input  wr_en, wr_bank, wr_addr_a, wr_addr_b,
    input  stage, busy, done, result_bank
  );
endinterface

// File: rtl/fft_stage_sequencer_addr_delay.sv
// LATENCY-deep shift register carrying the issued {en, bank, addr_a, addr_b}
// forward to the write port; a synchronous clear drops any pending writes.
module fft_addr_delay #(
  parameter int WIDTH   = 14,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/pair sequencer for an in-place radix-2 DIF FFT: issues one butterfly
// pair per cycle over all log2(N) stages and replays it to the write port.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int N       = 64,
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.master bus
);

  localparam int AW = $clog2(N);
  localparam int TW = $clog2(N / 2);
  localparam int SW = $clog2(AW + 1);
  localparam int DW = 2 + 2 * AW;

  localparam logic [TW-1:0] J_LAST     = TW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST     = SW'(AW - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] j_q, j_d;
  logic [SW-1:0] s_q, s_d;
  logic [3:0]    drainCnt_q, drainCnt_d;
  logic          rdEn_q, rdEn_d;
  logic          rdBank_q, rdBank_d;
  logic [AW-1:0] rdAddrA_q, rdAddrA_d;
  logic [AW-1:0] rdAddrB_q, rdAddrB_d;
  logic [TW-1:0] tfAddr_q, tfAddr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          issue;
  logic [TW-1:0] issueJ;
  logic [SW-1:0] issueS;
  logic [31:0]   issueA;

  // Outputs are computed one edge early so every pair appears registered in the
  // cycle it belongs to; DRAIN keeps the last read address visible.
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    s_d        = s_q;
    drainCnt_d = drainCnt_q;
    rdEn_d     = rdEn_q;
    rdBank_d   = rdBank_q;
    rdAddrA_d  = rdAddrA_q;
    rdAddrB_d  = rdAddrB_q;
    tfAddr_d   = tfAddr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issueJ     = j_q;
    issueS     = s_q;
    issueA     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          s_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          rdEn_d  = 1'b1;
          issue   = 1'b1;
          issueJ  = '0;
          issueS  = '0;
        end
      end
      ST_RUN: begin
        if (j_q == J_LAST) begin
          state_d    = ST_DRAIN;
          rdEn_d     = 1'b0;
          drainCnt_d = '0;
        end else begin
          j_d    = j_q + 1'b1;
          issue  = 1'b1;
          issueJ = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drainCnt_q == DRAIN_LAST) begin
          if (s_q < S_LAST) begin
            state_d = ST_RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
            rdEn_d  = 1'b1;
            issue   = 1'b1;
            issueJ  = '0;
            issueS  = s_q + 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      issueA    = fft_rd_addr(32'(issueJ), 32'(issueS), N);
      rdAddrA_d = AW'(issueA);
      rdAddrB_d = AW'(issueA + fft_span(32'(issueS), N));
      tfAddr_d  = TW'(fft_tf_addr(32'(issueJ), 32'(issueS), N));
      rdBank_d  = issueS[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      j_q        <= '0;
      s_q        <= '0;
      drainCnt_q <= '0;
      rdEn_q     <= 1'b0;
      rdBank_q   <= 1'b0;
      rdAddrA_q  <= '0;
      rdAddrB_q  <= '0;
      tfAddr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      s_q        <= s_d;
      drainCnt_q <= drainCnt_d;
      rdEn_q     <= rdEn_d;
      rdBank_q   <= rdBank_d;
      rdAddrA_q  <= rdAddrA_d;
      rdAddrB_q  <= rdAddrB_d;
      tfAddr_q   <= tfAddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  logic [DW-1:0] wrWord;

  fft_addr_delay #(
    .WIDTH   (DW),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  ({rdEn_q, ~rdBank_q, rdAddrA_q, rdAddrB_q}),
    .dout_o (wrWord)
  );

  assign bus.rd_en       = rdEn_q;
  assign bus.rd_bank     = rdBank_q;
  assign bus.rd_addr_a   = rdAddrA_q;
  assign bus.rd_addr_b   = rdAddrB_q;
  assign bus.tf_addr     = tfAddr_q;
  assign bus.wr_en       = wrWord[DW-1];
  assign bus.wr_bank     = wrWord[DW-2];
  assign bus.wr_addr_a   = wrWord[2*AW-1:AW];
  assign bus.wr_addr_b   = wrWord[AW-1:0];
  assign bus.stage       = s_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result_bank = 1'(AW % 2);

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control/address sequencer for the radix-2 in-place DIF FFT datapath: butterfly, twiddle ROM and two ping-pong dual-port BRAM banks.
- On a start pulse it walks all log2(N) stages.
- Each cycle it issues one butterfly pair's read addresses and twiddle index, and the matching write addresses after a fixed pipeline latency.
- It replaces the ad-hoc address logic inside the top-level FFT state machine.

Parameters:
N, 64, FFT length; power of two, 4..1024.
LATENCY, 3, cycles from read-address issue to write-back (BRAM read + butterfly pipeline); 1..15.
ADDR_WIDTH, $clog2(N), sample address width (derived).
TF_ADDR_WIDTH, $clog2(N/2), twiddle ROM address width (derived).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin an FFT pass; sampled only in IDLE
rd_en  out  1  read/issue strobe for the current butterfly pair
rd_bank  out  1  bank read this stage (0 = bank0)
rd_addr_a  out  ADDR_WIDTH  upper-leg read address
rd_addr_b  out  ADDR_WIDTH  lower-leg read address
tf_addr  out  TF_ADDR_WIDTH  twiddle ROM index for the issued pair
wr_en  out  1  write strobe for the butterfly result
wr_bank  out  1  bank written (always opposite of the bank read for that pair)
wr_addr_a  out  ADDR_WIDTH  upper-leg write address
wr_addr_b  out  ADDR_WIDTH  lower-leg write address
stage  out  $clog2(ADDR_WIDTH+1)  current stage index
busy  out  1  high from start acceptance through the DONE cycle
done  out  1  one-cycle pulse, final results valid
result_bank  out  1  bank holding the final results; constant ADDR_WIDTH[0]

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- All outputs are registered.
- Reset (rst_n=0 at a clk edge): state=IDLE; every output 0 except result_bank, which is the constant ADDR_WIDTH[0]; the delay line is cleared.
- Reset mid-operation aborts immediately; no pending writes are emitted afterwards.
- States:
  - IDLE: start=1 -> RUN with s=0, j=0.
  - RUN: issue one pair per cycle, j = 0..N/2-1. After j=N/2-1 -> DRAIN.
  - DRAIN: hold for LATENCY cycles, rd_en=0, read outputs hold their last values. Then, if s < ADDR_WIDTH-1: s++, j=0 -> RUN; else -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start is ignored while busy. A start coincident with the DONE cycle is ignored; it must be reasserted in IDLE.
- Per-pair arithmetic in stage s (all values are combinational in s and j, then registered):
  - span S = N >> (s+1)
  - mask = S-1
  - rd_addr_a = (j & mask) | ((j & ~mask) << 1)
  - rd_addr_b = rd_addr_a + S (no carry out)
  - tf_addr = (j & mask) << s, truncated to TF_ADDR_WIDTH
  - rd_bank = s[0]
- Write path:
  - {wr_en, wr_bank, wr_addr_a, wr_addr_b} equals {rd_en, ~rd_bank, rd_addr_a, rd_addr_b} delayed exactly LATENCY cycles, via a shift register.
  - wr_en is therefore high for the first LATENCY cycles of RUN in stages s>0? No: DRAIN guarantees every write of stage s lands before any read of stage s+1, so no read-after-write hazard exists.
  - wr_en is 0 during the first LATENCY cycles of each RUN and high during the DRAIN cycles.
- Timing:
  - The first RUN cycle is the cycle after the accepting edge.
  - done is asserted ADDR_WIDTH*(N/2+LATENCY)+1 cycles after that edge.
  - busy deasserts together with the end of the done pulse.
- Bank usage: input samples sit in bank0; stage s reads bank s[0] and writes the other bank.

Decomposition:
- Shared package fft_pkg:
  - state encoding enum (IDLE, RUN, DRAIN, DONE)
  - function clog2-derived widths
  - address-generation function fft_rd_addr(j, s, N)
  - twiddle-index function fft_tf_addr(j, s, N)
- These functions are shared with the golden model in the bench.
- One natural sub-module, fft_addr_delay: a parameterised LATENCY-deep shift register carrying {en, bank, addr_a, addr_b}, with synchronous active-low clear.

Test Plan:
- Reset, then idle: rst_n=0 for 2 cycles -> all outputs 0, result_bank=0 (N=64), busy=0; start held 0 for 10 cycles -> no rd_en.
- N=8, LATENCY=3, start pulse -> stage0 issues (a,b,tf) = (0,4,0)(1,5,1)(2,6,2)(3,7,3) with rd_bank=0.
- Same run, stage1 -> (0,2,0)(1,3,2)(4,6,0)(5,7,2) with rd_bank=1; stage2 -> (0,1,0)(2,3,0)(4,5,0)(6,7,0) with rd_bank=0.
- Same run, write side -> each wr triple matches the rd triple 3 cycles earlier with inverted bank; wr_en never overlaps the next stage's rd_en; done pulses exactly 22 cycles after start; result_bank=1.
- start pulsed again at cycles 5 and 22 of a run (N=8) -> both ignored; a fresh start in IDLE restarts cleanly at (0,4,0).
- rst_n=0 mid-stage1 (N=64, LATENCY=3) -> next cycle IDLE, rd_en=wr_en=0, and no delayed writes appear over the following 5 cycles.
